// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter: FSM state encoding and
// default sizing constants used by freq_meter and its bench.
package freq_meter_pkg;

    // Measurement sequencer states (2-bit encoding, IDLE is the reset value)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } fm_state_t;

    // Default gate window length in clk cycles
    localparam int DEF_GATE_CYCLES = 1000;

    // Default width of the edge counter and of the reported result
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// sync_edge_det: brings an asynchronous level into the clk domain through a
// two-flop synchronizer and flags its rising edges with a one-cycle pulse.
// Generic so it can be reused for any other asynchronous input.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Two-stage synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= d_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // A rise is a synchronized high that was low one cycle earlier; the
    // pulse appears 2-3 clk cycles after the asynchronous edge.
    assign rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated frequency meter. Counts rising edges of the asynchronous
// input fin over a window of GATE_CYCLES clk cycles that starts on a fin
// edge, then reports the count.
//
// Build option: FREQ_METER_CONT_EN. When defined, a finished measurement
// re-arms immediately (continuous back-to-back results after one start);
// only rst brings the block back to IDLE. When undefined, single-shot.
//
// Output protocol: there is no ready/back-pressure. valid is a one-cycle
// pulse in the cycle cnt_out/ovf take a new result; the consumer must take
// it that cycle. cnt_out and ovf then hold until the next result or rst.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fin,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_out,
    output logic             valid,
    output logic             ovf,
    output fm_state_t        o_dbg_state
);

    // Gate timer only needs to reach GATE_CYCLES-1
    localparam int            TW         = $clog2(GATE_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);

    // A window shorter than two cycles cannot separate arming and counting
    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("freq_meter: GATE_CYCLES must be at least 2");
    end

    logic             w_rise;
    logic             w_timer_last;
    logic [CNT_W-1:0] w_count_next;
    logic             w_ovf_next;

    fm_state_t        r_state;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf_flag;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt_out;
    logic             r_valid;
    logic             r_ovf;

    sync_edge_det u_fin_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (fin),
        .rise    (w_rise)
    );

    assign w_timer_last = (r_timer == TIMER_LAST);

    // Saturating edge count including this cycle's rise; the sticky flag
    // records a rise that arrived while the counter was already full.
    always_comb begin
        w_count_next = r_count;
        w_ovf_next   = r_ovf_flag;
        if (w_rise) begin
            if (&r_count) begin
                w_ovf_next = 1'b1;
            end else begin
                w_count_next = r_count + CNT_W'(1);
            end
        end
    end

    // Measurement sequencer with registered outputs. The result is loaded on
    // the transition into DONE so valid coincides with the DONE cycle, while
    // busy is still high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_count    <= '0;
            r_ovf_flag <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt_out  <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // start wins over any rise seen in the same cycle
                    if (start) begin
                        r_state <= ARM;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                ARM: begin
                    // The arming edge only aligns the window; it is not counted
                    if (w_rise) begin
                        r_state    <= GATE;
                        r_timer    <= '0;
                        r_count    <= '0;
                        r_ovf_flag <= 1'b0;
                    end else if (w_timer_last) begin
                        // No fin edge within a full window: report zero
                        r_state   <= DONE;
                        r_cnt_out <= '0;
                        r_ovf     <= 1'b0;
                        r_valid   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                GATE: begin
                    r_count    <= w_count_next;
                    r_ovf_flag <= w_ovf_next;
                    if (w_timer_last) begin
                        r_state   <= DONE;
                        r_cnt_out <= w_count_next;
                        r_ovf     <= w_ovf_next;
                        r_valid   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                DONE: begin
`ifdef FREQ_METER_CONT_EN
                    // Continuous mode: re-arm straight away, stay busy
                    r_state <= ARM;
                    r_timer <= '0;
`else
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
`endif
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign cnt_out     = r_cnt_out;
    assign valid       = r_valid;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (16-bit and 3-bit counters, 100-cycle
// gate) share one stimulus. Expected results come from the edge arithmetic
// floor(GATE/period), saturated to the counter width.
module tb_freq_meter;

    localparam int G = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fin = 1'b0;
    logic        start = 1'b0;

    logic        busy_a, valid_a, ovf_a;
    logic [15:0] cnt_a;
    logic [1:0]  dbg_a;
    logic        busy_b, valid_b, ovf_b;
    logic [2:0]  cnt_b;
    logic [1:0]  dbg_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fin_period = 0;
    int t_start = 0;
    int last_valid_cyc = 0;
    logic valid_prev = 1'b0;

    logic [16:0] exp_a_q[$];
    logic [3:0]  exp_b_q[$];
    logic [16:0] e_a;
    logic [3:0]  e_b;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .fin(fin), .start(start),
        .busy(busy_a), .cnt_out(cnt_a), .valid(valid_a), .ovf(ovf_a),
        .o_dbg_state(dbg_a)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .fin(fin), .start(start),
        .busy(busy_b), .cnt_out(cnt_b), .valid(valid_b), .ovf(ovf_b),
        .o_dbg_state(dbg_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // fin source: period in clk cycles, edges placed 3 ns after posedge so
    // the synchronizer sees them deterministically. period < 4 holds fin low.
    initial begin
        forever begin
            if (fin_period < 4) begin
                fin = 1'b0;
                @(posedge clk); #3;
            end else begin
                fin = 1'b1;
                repeat (fin_period / 2) @(posedge clk);
                #3;
                fin = 1'b0;
                repeat (fin_period - fin_period / 2) @(posedge clk);
                #3;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: edges in a window aligned to a fin edge
    task automatic push_expected(input int p);
        int edges;
        edges = (p < 4) ? 0 : G / p;
        exp_a_q.push_back({(edges > 65535), (edges > 65535) ? 16'hFFFF : 16'(edges)});
        exp_b_q.push_back({(edges > 7), (edges > 7) ? 3'd7 : 3'(edges)});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            valid_prev = 1'b0;
        end else begin
            if (valid_a) begin
                last_valid_cyc = cyc;
                if (exp_a_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid_a: cnt=%0d with nothing expected", cnt_a);
                end else begin
                    e_a = exp_a_q.pop_front();
                    check("cnt_a", cnt_a, e_a[15:0]);
                    check("ovf_a", ovf_a, e_a[16]);
                    check("busy_at_valid_a", busy_a, 1);
                end
            end
            if (valid_b) begin
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid_b: cnt=%0d with nothing expected", cnt_b);
                end else begin
                    e_b = exp_b_q.pop_front();
                    check("cnt_b", cnt_b, e_b[2:0]);
                    check("ovf_b", ovf_b, e_b[3]);
                end
            end
`ifndef FREQ_METER_CONT_EN
            if (valid_prev) check("busy_after_valid", busy_a, 0);
`endif
            valid_prev = valid_a;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_period(input int p);
        fin_period = p;
        repeat (90) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, (exp_a_q.size() == 0 && exp_b_q.size() == 0), 1);
        exp_a_q.delete();
        exp_b_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic measure(input int p, input string name);
        set_period(p);
        push_expected(p);
        pulse_start();
        #1;
        check("busy_after_start", busy_a, 1);
        wait_drain(400, name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int p;
        do_reset();
        check("rst_busy", busy_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_state", dbg_a, 0);

`ifdef FREQ_METER_CONT_EN
        begin
            int n;
            logic dropped;
            set_period(10);
            for (int i = 0; i < 4; i++) push_expected(10);
            pulse_start();
            n = 0;
            dropped = 1'b0;
            while (exp_a_q.size() != 0 && n < 1500) begin
                @(negedge clk); #1;
                if (!busy_a) dropped = 1'b1;
                n++;
            end
            check("cont_all_results", exp_a_q.size(), 0);
            check("cont_busy_held", dropped, 0);
            #3 rst = 1'b1;
            #1;
            check("cont_rst_busy", busy_a, 0);
            check("cont_rst_cnt", cnt_a, 0);
            exp_a_q.delete();
            exp_b_q.delete();
            repeat (2) @(negedge clk);
            #2 rst = 1'b0;
            repeat (300) @(negedge clk);
            check("cont_idle_after_rst", busy_a, 0);
        end
`else
        // Nominal: period 10 -> 10 edges (3-bit copy saturates)
        measure(10, "basic_p10");

        // ARM timeout with fin held low
        set_period(0);
        push_expected(0);
        pulse_start();
        wait_drain(400, "timeout_done");
        lat = last_valid_cyc - t_start;
        checks++;
        if (lat < 101 || lat > 102) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected 101..102", lat);
        end

        // Saturation then recovery
        measure(4, "sat_p4");
        measure(20, "nosat_p20");

        // Second start during GATE is ignored
        set_period(10);
        push_expected(10);
        pulse_start();
        repeat (60) @(negedge clk);
        check("state_gate", dbg_a, 2);
        pulse_start();
        wait_drain(400, "start_in_gate");
        repeat (150) @(negedge clk);

        // Asynchronous reset mid-GATE aborts the run
        set_period(8);
        push_expected(8);
        pulse_start();
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_cnt", cnt_a, 0);
        check("abort_ovf_b", ovf_b, 0);
        check("abort_valid", valid_a, 0);
        exp_a_q.delete();
        exp_b_q.delete();
        @(negedge clk);
        #3 rst = 1'b0;
        repeat (250) @(negedge clk);
        check("abort_idle", busy_a, 0);
        measure(8, "after_abort_p8");

        // Randomized periods
        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(4, 40);
            measure(p, "random_period");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Gated frequency meter, the measuring counterpart of the team's programmable preset divider. It counts rising edges of an asynchronous input `fin` over a fixed window of `clk` cycles and reports the count. Used to check divider output frequency in-system, or to recover the divisor from a divided clock. It sits beside the divider and is driven by the same `clk`.

Parameters:
- GATE_CYCLES, 1000: gate window length in `clk` cycles (>=2).
- CNT_W, 16: width of the edge counter and the result.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- fin  input  1  signal under measurement; asynchronous to `clk`.
- start  input  1  one-cycle request to begin a measurement.
- busy  output  1  high while a measurement is in progress.
- cnt_out  output  CNT_W  last measured edge count; held between results.
- valid  output  1  one-cycle pulse when `cnt_out` updates.
- ovf  output  1  last result saturated; updates with `valid`.

Behaviour:
- Reset: asynchronous, active-high. All of the following are 0: state=IDLE, sync flops, edge register, timers, `busy`, `cnt_out`, `valid`, `ovf`.
- Input path:
  - 2-flop synchronizer on `fin`, then an edge register.
  - rise = sync2 & ~prev.
  - Latency from a `fin` rising edge to the rise pulse is 2-3 `clk` cycles.
  - `fin` high or low time must be >=2 `clk` cycles. Narrower pulses may be missed; this is not detected.
- FSM states: IDLE, ARM, GATE, DONE.
- IDLE:
  - `start`=1 -> ARM next cycle; the gate timer clears.
  - `busy`=0 in IDLE; `busy`=1 in ARM, GATE and DONE.
- ARM:
  - Waits for the first rise pulse so the window aligns to a `fin` edge. That edge is not counted.
  - rise -> GATE; the edge counter clears.
  - If no rise within GATE_CYCLES cycles (timeout) -> DONE with result 0 and `ovf`=0.
- GATE:
  - Samples rise in exactly GATE_CYCLES consecutive cycles, the first being the cycle after the arming edge.
  - Each sampled rise increments the counter.
  - When the counter is at all-ones, it holds and the sticky overflow flag sets.
  - After the last window cycle -> DONE.
- DONE (one cycle):
  - `cnt_out` <= counter, `ovf` <= overflow flag, `valid`=1.
  - Next state is IDLE.
- `start` is ignored outside IDLE; there is no queuing.
- `start` and rise in the same cycle in IDLE: only `start` acts.
- `rst` mid-measurement aborts immediately: no `valid`, `cnt_out` returns to 0.
- Counters are unsigned. The gate timer width is $clog2(GATE_CYCLES+1).
- Frequency in Hz = `cnt_out` × f_clk / GATE_CYCLES. The divider's toggle output gives `cnt_out` ≈ GATE_CYCLES / (2·(256−d)).

Optional Feature:
- Macro: FREQ_METER_CONT_EN.
- Defined:
  - DONE goes directly to ARM instead of IDLE, giving continuous back-to-back measurements once started.
  - `busy` stays 1 throughout.
  - `start` is still needed once from IDLE.
  - Only `rst` returns the block to IDLE.
- Undefined: single-shot behaviour as described above.

Decomposition:
- Shared package freq_meter_pkg holds:
  - the state enum (IDLE, ARM, GATE, DONE), 2-bit;
  - the default GATE_CYCLES and CNT_W constants.
- One sub-module, sync_edge_det:
  - 2-flop synchronizer plus rise detect;
  - ports `clk`, `rst`, `d_async`, `rise`;
  - reusable for other asynchronous inputs.

Test Plan:
- GATE_CYCLES=100, `fin` period 10 `clk` (5 high/5 low), pulse `start` -> `busy`=1, then one `valid` with `cnt_out`=10 and `ovf`=0; `busy`=0 the cycle after `valid`.
- GATE_CYCLES=100, `fin` held 0, `start` -> ARM timeout; `valid` exactly 101-102 cycles after `start` with `cnt_out`=0.
- CNT_W=3, GATE_CYCLES=100, `fin` period 4 -> `cnt_out`=7 and `ovf`=1; a following run with period 20 -> `cnt_out`=5 and `ovf`=0.
- `start` pulsed again during GATE -> ignored; exactly one `valid`, and the count equals the undisturbed value.
- Assert `rst` for 1 cycle mid-GATE, asynchronous to `clk` -> outputs 0 immediately; no `valid` until a new `start`; a new run returns the correct count.
- FREQ_METER_CONT_EN defined, period 10, GATE_CYCLES=100 -> repeated `valid` pulses each with `cnt_out`=10; `busy` never drops until `rst`.
